// File: rtl/mem_access_unit.sv
// ---------------------------------------------------------------------------
// mem_access_unit
//
// Memory-access stage that sits directly behind the execute ALU. It takes the
// ALU result, the decoded alucode and the store operand. For loads and stores
// it runs a req/gnt/rvalid handshake to data memory. It produces byte enables
// and lane-steered store data, and it extracts load data with sign or zero
// extension. Non-memory ops pass straight through to write-back with one cycle
// of latency. The upstream stage is stalled while a memory transaction is
// outstanding.
//
// Optional build macro:
//   MISALIGN_TRAP_EN - misaligned loads/stores are caught in IDLE. No request
//                      is issued and bus_err pulses instead. When the macro is
//                      undefined, misaligned accesses use the aligned word and
//                      the lane bits are truncated.
//
// Parameters:
//   ADDR_WIDTH - number of low address bits driven on dmem_addr
//   WAIT_LIMIT - cycles to wait for gnt/rvalid before abort (0 = unlimited)
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   ex_valid            op from execute is valid
//   ex_alucode          decoded op
//   ex_result           ALU result / effective address
//   ex_store_data       rs2 value for stores
//   ex_rd               destination register
//   stall               upstream must hold its op (state != IDLE)
//   dmem_req/we/addr    memory request, write flag, word-aligned address
//   dmem_be/wdata       byte enables, lane-steered store data
//   dmem_gnt            memory accepted the request
//   dmem_rvalid/rdata   load data valid, raw load word
//   wb_valid/rd/data    write-back pulse, destination, value
//   bus_err             one-cycle pulse on timeout or trapped misalignment
// ---------------------------------------------------------------------------
module mem_access_unit #(
   parameter int ADDR_WIDTH = 32,
   parameter int WAIT_LIMIT = 0
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  ex_valid,
   input  logic [5:0]            ex_alucode,
   input  logic [31:0]           ex_result,
   input  logic [31:0]           ex_store_data,
   input  logic [4:0]            ex_rd,
   output logic                  stall,
   output logic                  dmem_req,
   output logic                  dmem_we,
   output logic [ADDR_WIDTH-1:0] dmem_addr,
   output logic [3:0]            dmem_be,
   output logic [31:0]           dmem_wdata,
   input  logic                  dmem_gnt,
   input  logic                  dmem_rvalid,
   input  logic [31:0]           dmem_rdata,
   output logic                  wb_valid,
   output logic [4:0]            wb_rd,
   output logic [31:0]           wb_data,
   output logic                  bus_err
);

   // Decoded op codes shared with the execute stage.
   localparam logic [5:0] ALU_LB  = 6'd20;
   localparam logic [5:0] ALU_LH  = 6'd21;
   localparam logic [5:0] ALU_LW  = 6'd22;
   localparam logic [5:0] ALU_LBU = 6'd23;
   localparam logic [5:0] ALU_LHU = 6'd24;
   localparam logic [5:0] ALU_SB  = 6'd25;
   localparam logic [5:0] ALU_SH  = 6'd26;
   localparam logic [5:0] ALU_SW  = 6'd27;

   localparam bit          TIMEOUT_EN = (WAIT_LIMIT > 0);
   localparam logic [31:0] WAIT_LAST  = TIMEOUT_EN ? 32'(WAIT_LIMIT - 1) : 32'd0;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t                state_q, state_d;
   logic [5:0]            op_q, op_d;
   logic [1:0]            lane_q, lane_d;
   logic [4:0]            rd_q, rd_d;
   logic                  we_q, we_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [3:0]            be_q, be_d;
   logic [31:0]           wdata_q, wdata_d;
   logic [31:0]           wait_cnt_q, wait_cnt_d;
   logic                  wb_valid_q, wb_valid_d;
   logic [4:0]            wb_rd_q, wb_rd_d;
   logic [31:0]           wb_data_q, wb_data_d;
   logic                  bus_err_q, bus_err_d;
   logic                  trap_hit;

   function automatic logic is_load(input logic [5:0] op);
      return (op == ALU_LB) || (op == ALU_LH) || (op == ALU_LW) ||
             (op == ALU_LBU) || (op == ALU_LHU);
   endfunction

   function automatic logic is_store(input logic [5:0] op);
      return (op == ALU_SB) || (op == ALU_SH) || (op == ALU_SW);
   endfunction

   // A halfword access has the same lane truncation for SH/LH/LHU. Lane[0] is dropped.
   function automatic logic [3:0] byte_enables(input logic [5:0] op, input logic [1:0] lane);
      logic [3:0] be;
      be = 4'b1111;
      if (op == ALU_SB) begin
         be = 4'b0001 << lane;
      end else if (op == ALU_SH) begin
         be = lane[1] ? 4'b1100 : 4'b0011;
      end
      return be;
   endfunction

   // Replicate the operand across every lane so that memory can pick its lane from dmem_be.
   function automatic logic [31:0] steer_store(input logic [5:0] op, input logic [31:0] data);
      logic [31:0] w;
      w = data;
      if (op == ALU_SB) begin
         w = {4{data[7:0]}};
      end else if (op == ALU_SH) begin
         w = {2{data[15:0]}};
      end
      return w;
   endfunction

   function automatic logic [31:0] extract_load(input logic [5:0] op, input logic [1:0] lane,
                                                input logic [31:0] word);
      logic [7:0]  byte_sel;
      logic [15:0] half_sel;
      logic [31:0] res;
      byte_sel = word[{lane, 3'b000} +: 8];
      half_sel = lane[1] ? word[31:16] : word[15:0];
      res      = word;
      case (op)
         ALU_LB:  res = {{24{byte_sel[7]}}, byte_sel};
         ALU_LBU: res = {24'd0, byte_sel};
         ALU_LH:  res = {{16{half_sel[15]}}, half_sel};
         ALU_LHU: res = {16'd0, half_sel};
         default: res = word;
      endcase
      return res;
   endfunction

`ifdef MISALIGN_TRAP_EN
   // A halfword access is misaligned on an odd lane. A word access is misaligned on any nonzero lane.
   function automatic logic is_misaligned(input logic [5:0] op, input logic [1:0] lane);
      logic half_op;
      logic word_op;
      half_op = (op == ALU_LH) || (op == ALU_LHU) || (op == ALU_SH);
      word_op = (op == ALU_LW) || (op == ALU_SW);
      return (half_op && lane[0]) || (word_op && (lane != 2'b00));
   endfunction

   assign trap_hit = is_misaligned(ex_alucode, ex_result[1:0]);
`else
   assign trap_hit = 1'b0;
`endif

   // The request stays high for the whole of REQ. The captured addr/be/wdata/we
   // registers do not change until the grant, so they are stable throughout.
   assign stall      = (state_q != IDLE);
   assign dmem_req   = (state_q == REQ);
   assign dmem_we    = we_q;
   assign dmem_addr  = addr_q;
   assign dmem_be    = be_q;
   assign dmem_wdata = wdata_q;
   assign wb_valid   = wb_valid_q;
   assign wb_rd      = wb_rd_q;
   assign wb_data    = wb_data_q;
   assign bus_err    = bus_err_q;

   // Next-state and output logic. wb_valid and bus_err default to 0, so they are one-cycle pulses.
   // In IDLE the unit captures the op. In REQ it waits for the grant. In RESP it
   // waits for load data. The wait counter restarts whenever REQ or RESP is entered.
   always_comb begin
      state_d    = state_q;
      op_d       = op_q;
      lane_d     = lane_q;
      rd_d       = rd_q;
      we_d       = we_q;
      addr_d     = addr_q;
      be_d       = be_q;
      wdata_d    = wdata_q;
      wait_cnt_d = wait_cnt_q;
      wb_valid_d = 1'b0;
      wb_rd_d    = wb_rd_q;
      wb_data_d  = wb_data_q;
      bus_err_d  = 1'b0;

      case (state_q)
         IDLE: begin
            if (ex_valid) begin
               if (!is_load(ex_alucode) && !is_store(ex_alucode)) begin
                  wb_valid_d = 1'b1;
                  wb_data_d  = ex_result;
                  wb_rd_d    = ex_rd;
               end else if (trap_hit) begin
                  bus_err_d = 1'b1;
               end else begin
                  op_d       = ex_alucode;
                  lane_d     = ex_result[1:0];
                  rd_d       = ex_rd;
                  we_d       = is_store(ex_alucode);
                  addr_d     = {ex_result[ADDR_WIDTH-1:2], 2'b00};
                  be_d       = byte_enables(ex_alucode, ex_result[1:0]);
                  wdata_d    = steer_store(ex_alucode, ex_store_data);
                  wait_cnt_d = 32'd0;
                  state_d    = REQ;
               end
            end
         end

         REQ: begin
            if (dmem_gnt) begin
               wait_cnt_d = 32'd0;
               state_d    = we_q ? IDLE : RESP;
            end else if (TIMEOUT_EN && (wait_cnt_q == WAIT_LAST)) begin
               bus_err_d = 1'b1;
               state_d   = IDLE;
            end else if (TIMEOUT_EN) begin
               wait_cnt_d = wait_cnt_q + 32'd1;
            end
         end

         RESP: begin
            if (dmem_rvalid) begin
               wb_valid_d = 1'b1;
               wb_rd_d    = rd_q;
               wb_data_d  = extract_load(op_q, lane_q, dmem_rdata);
               state_d    = IDLE;
            end else if (TIMEOUT_EN && (wait_cnt_q == WAIT_LAST)) begin
               bus_err_d = 1'b1;
               state_d   = IDLE;
            end else if (TIMEOUT_EN) begin
               wait_cnt_d = wait_cnt_q + 32'd1;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and output registers. Reset abandons any transaction that is in flight.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         op_q       <= 6'd0;
         lane_q     <= 2'd0;
         rd_q       <= 5'd0;
         we_q       <= 1'b0;
         addr_q     <= '0;
         be_q       <= 4'd0;
         wdata_q    <= 32'd0;
         wait_cnt_q <= 32'd0;
         wb_valid_q <= 1'b0;
         wb_rd_q    <= 5'd0;
         wb_data_q  <= 32'd0;
         bus_err_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         op_q       <= op_d;
         lane_q     <= lane_d;
         rd_q       <= rd_d;
         we_q       <= we_d;
         addr_q     <= addr_d;
         be_q       <= be_d;
         wdata_q    <= wdata_d;
         wait_cnt_q <= wait_cnt_d;
         wb_valid_q <= wb_valid_d;
         wb_rd_q    <= wb_rd_d;
         wb_data_q  <= wb_data_d;
         bus_err_q  <= bus_err_d;
      end
   end

endmodule
